// File: rtl/pipe_referee.sv
// ============================================================================
// Module   : pipe_referee
// Brief    : Scrolling pipe, collision and score referee for a flappy game.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_referee #(
    parameter int PIPE_W    = 60,
    parameter int GAP_H     = 160,
    parameter int PIPE_STEP = 2,
    parameter int SPAWN_X   = 640,
    parameter int FLOOR_Y   = 479
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       Tick,
    input  logic       q_Initial,
    input  logic       q_Flight,
    input  logic [9:0] Bird_X_L,
    input  logic [9:0] Bird_X_R,
    input  logic [9:0] Bird_Y_T,
    input  logic [9:0] Bird_Y_B,
    output logic       Stop,
    output logic [9:0] Pipe_X_L,
    output logic [9:0] Gap_Y_T,
    output logic [9:0] Gap_Y_B,
    output logic [7:0] Score,
    output logic       q_Idle,
    output logic       q_Run,
    output logic       q_Hit
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_RUN  = 3'b010,
        S_HIT  = 3'b100
    } state_t;

    localparam logic [9:0]  c_SPAWN_X    = 10'(SPAWN_X);
    localparam logic [9:0]  c_STEP       = 10'(PIPE_STEP);
    localparam logic [9:0]  c_GAP_H      = 10'(GAP_H);
    localparam logic [9:0]  c_IDLE_GAP_T = 10'd160;
    localparam logic [9:0]  c_IDLE_GAP_B = 10'd320;
    localparam logic [9:0]  c_GAP_BASE   = 10'd64;
    localparam logic [10:0] c_PIPE_W     = 11'(PIPE_W);
    localparam logic [10:0] c_FLOOR_Y    = 11'(FLOOR_Y);
    localparam logic [7:0]  c_LFSR_SEED  = 8'hA5;
    localparam logic [7:0]  c_LFSR_TAPS  = 8'hB8;

    state_t      r_state;
    logic [7:0]  r_lfsr;
    logic        r_passed;

    logic [10:0] w_pipe_l;
    logic [10:0] w_pipe_r;
    logic        w_overlap_x;
    logic        w_outside_gap;
    logic        w_hit;
    logic        w_cleared;
    logic [7:0]  w_lfsr_next;
    logic [9:0]  w_spawn_gap_t;

    // Widen to 11 bits so Pipe_X_L + PIPE_W never wraps near the right edge.
    assign w_pipe_l      = {1'b0, Pipe_X_L};
    assign w_pipe_r      = w_pipe_l + c_PIPE_W - 11'd1;
    assign w_overlap_x   = ({1'b0, Bird_X_R} >= w_pipe_l) && ({1'b0, Bird_X_L} <= w_pipe_r);
    assign w_outside_gap = ({1'b0, Bird_Y_T} < {1'b0, Gap_Y_T}) ||
                           ({1'b0, Bird_Y_B} > {1'b0, Gap_Y_B});
    assign w_hit         = (w_overlap_x && w_outside_gap) || ({1'b0, Bird_Y_B} >= c_FLOOR_Y);
    assign w_cleared     = (w_pipe_l + c_PIPE_W) < {1'b0, Bird_X_L};

    assign w_lfsr_next   = r_lfsr[0] ? ({1'b0, r_lfsr[7:1]} ^ c_LFSR_TAPS)
                                     : {1'b0, r_lfsr[7:1]};
    assign w_spawn_gap_t = c_GAP_BASE + {2'b00, r_lfsr};

    assign q_Idle = r_state[0];
    assign q_Run  = r_state[1];
    assign q_Hit  = r_state[2];

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            Stop     <= 1'b0;
            Score    <= 8'd0;
            Pipe_X_L <= c_SPAWN_X;
            Gap_Y_T  <= c_IDLE_GAP_T;
            Gap_Y_B  <= c_IDLE_GAP_B;
            r_passed <= 1'b0;
            r_lfsr   <= c_LFSR_SEED;
        end else begin
            r_lfsr <= w_lfsr_next;
            case (r_state)
                S_IDLE: begin
                    Pipe_X_L <= c_SPAWN_X;
                    Gap_Y_T  <= c_IDLE_GAP_T;
                    Gap_Y_B  <= c_IDLE_GAP_B;
                    r_passed <= 1'b0;
                    Stop     <= 1'b0;
                    if (q_Flight) begin
                        r_state <= S_RUN;
                        Score   <= 8'd0;
                    end
                end
                S_RUN: begin
                    // A collision pre-empts movement, respawn and scoring.
                    if (w_hit) begin
                        r_state <= S_HIT;
                        Stop    <= 1'b1;
                    end else if (!q_Flight) begin
                        r_state  <= S_IDLE;
                        Pipe_X_L <= c_SPAWN_X;
                        Gap_Y_T  <= c_IDLE_GAP_T;
                        Gap_Y_B  <= c_IDLE_GAP_B;
                        r_passed <= 1'b0;
                    end else begin
                        if (!r_passed && w_cleared) begin
                            r_passed <= 1'b1;
                            if (Score != 8'hFF) begin
                                Score <= Score + 8'd1;
                            end
                        end
                        if (Tick) begin
                            if (Pipe_X_L >= c_STEP) begin
                                Pipe_X_L <= Pipe_X_L - c_STEP;
                            end else begin
                                Pipe_X_L <= c_SPAWN_X;
                                Gap_Y_T  <= w_spawn_gap_t;
                                Gap_Y_B  <= w_spawn_gap_t + c_GAP_H;
                                r_passed <= 1'b0;
                            end
                        end
                    end
                end
                S_HIT: begin
                    if (q_Initial) begin
                        r_state  <= S_IDLE;
                        Stop     <= 1'b0;
                        Pipe_X_L <= c_SPAWN_X;
                        Gap_Y_T  <= c_IDLE_GAP_T;
                        Gap_Y_B  <= c_IDLE_GAP_B;
                        r_passed <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    Stop    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_referee.sv
// ============================================================================
// Module   : tb_pipe_referee
// Brief    : Self-checking bench for pipe_referee with a behavioural game model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_referee;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       Tick = 1'b0;
    logic       q_Initial = 1'b0;
    logic       q_Flight = 1'b0;
    logic [9:0] Bird_X_L = 10'd0;
    logic [9:0] Bird_X_R = 10'd10;
    logic [9:0] Bird_Y_T = 10'd200;
    logic [9:0] Bird_Y_B = 10'd220;
    logic       Stop;
    logic [9:0] Pipe_X_L;
    logic [9:0] Gap_Y_T;
    logic [9:0] Gap_Y_B;
    logic [7:0] Score;
    logic       q_Idle;
    logic       q_Run;
    logic       q_Hit;

    int checks = 0;
    int errors = 0;

    // Behavioural game model: mode 0 = idle, 1 = running, 2 = crashed.
    int m_mode   = 0;
    int m_x      = 640;
    int m_gt     = 160;
    int m_gb     = 320;
    int m_score  = 0;
    int m_passed = 0;
    int m_stop   = 0;
    int m_lfsr   = 'hA5;

    pipe_referee dut (
        .Clk       (Clk),
        .reset     (reset),
        .Tick      (Tick),
        .q_Initial (q_Initial),
        .q_Flight  (q_Flight),
        .Bird_X_L  (Bird_X_L),
        .Bird_X_R  (Bird_X_R),
        .Bird_Y_T  (Bird_Y_T),
        .Bird_Y_B  (Bird_Y_B),
        .Stop      (Stop),
        .Pipe_X_L  (Pipe_X_L),
        .Gap_Y_T   (Gap_Y_T),
        .Gap_Y_B   (Gap_Y_B),
        .Score     (Score),
        .q_Idle    (q_Idle),
        .q_Run     (q_Run),
        .q_Hit     (q_Hit)
    );

    always #5 Clk = ~Clk;

    task automatic model_idle_pipe();
        m_x = 640; m_gt = 160; m_gb = 320; m_passed = 0;
    endtask

    task automatic model_update();
        int  next_lfsr;
        bit  hit;
        next_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB8) : (m_lfsr / 2);
        if (reset) begin
            m_mode = 0; m_stop = 0; m_score = 0; m_lfsr = 'hA5;
            model_idle_pipe();
        end else begin
            hit = ((int'(Bird_X_R) >= m_x) && (int'(Bird_X_L) <= m_x + 59) &&
                   ((int'(Bird_Y_T) < m_gt) || (int'(Bird_Y_B) > m_gb))) ||
                  (int'(Bird_Y_B) >= 479);
            if (m_mode == 0) begin
                model_idle_pipe();
                if (q_Flight) begin m_mode = 1; m_score = 0; end
            end else if (m_mode == 1) begin
                if (hit) begin
                    m_mode = 2; m_stop = 1;
                end else if (!q_Flight) begin
                    m_mode = 0; model_idle_pipe();
                end else begin
                    if (m_passed == 0 && m_x + 60 < int'(Bird_X_L)) begin
                        m_passed = 1;
                        if (m_score < 255) m_score = m_score + 1;
                    end
                    if (Tick) begin
                        if (m_x >= 2) m_x = m_x - 2;
                        else begin
                            m_x = 640; m_gt = 64 + m_lfsr; m_gb = m_gt + 160; m_passed = 0;
                        end
                    end
                end
            end else if (q_Initial) begin
                m_mode = 0; m_stop = 0; model_idle_pipe();
            end
            m_lfsr = next_lfsr;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; Tick = 1'b0; q_Flight = 1'b0; q_Initial = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic set_bird(input int xl, input int xr, input int yt, input int yb);
        Bird_X_L = 10'(xl); Bird_X_R = 10'(xr); Bird_Y_T = 10'(yt); Bird_Y_B = 10'(yb);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++;
        if ({q_Idle, q_Run, q_Hit, Stop} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags: got %b expected 1000", {q_Idle, q_Run, q_Hit, Stop});
        end
        checks++;
        if ({Pipe_X_L, Gap_Y_T, Gap_Y_B, Score} !== {10'd640, 10'd160, 10'd320, 8'd0}) begin
            errors++; $display("FAIL reset_pipe: got x=%0d gt=%0d gb=%0d score=%0d expected 640/160/320/0",
                               Pipe_X_L, Gap_Y_T, Gap_Y_B, Score);
        end
        reset = 1'b0; Tick = 1'b1; q_Flight = 1'b0;
        repeat (3) step();
        Tick = 1'b0;
        checks++;
        if (Pipe_X_L !== 10'd640 || q_Idle !== 1'b1) begin
            errors++; $display("FAIL idle_tick_ignored: got x=%0d idle=%b expected 640/1", Pipe_X_L, q_Idle);
        end
    endtask

    task automatic test_clean_pass();
        bit stop_seen;
        do_reset();
        set_bird(230, 285, 220, 240);
        q_Flight = 1'b1;
        step();
        checks++;
        if ({q_Idle, q_Run, q_Hit} !== 3'b010 || Score !== 8'd0) begin
            errors++; $display("FAIL run_entry: got flags=%b score=%0d expected 010/0", {q_Idle, q_Run, q_Hit}, Score);
        end
        Tick = 1'b1;
        stop_seen = 1'b0;
        repeat (236) begin
            step();
            if (Stop !== 1'b0) stop_seen = 1'b1;
        end
        Tick = 1'b0;
        checks++;
        if (Pipe_X_L !== 10'd168 || Score !== 8'd0) begin
            errors++; $display("FAIL pass_position: got x=%0d score=%0d expected 168/0", Pipe_X_L, Score);
        end
        step();
        checks++;
        if (Score !== 8'd1 || Pipe_X_L !== 10'd168) begin
            errors++; $display("FAIL pass_score: got score=%0d x=%0d expected 1/168", Score, Pipe_X_L);
        end
        checks++;
        if (stop_seen !== 1'b0 || Stop !== 1'b0) begin
            errors++; $display("FAIL pass_no_stop: got stop_seen=%b expected 0", stop_seen);
        end
    endtask

    task automatic test_pipe_hit();
        do_reset();
        set_bird(230, 285, 100, 120);
        q_Flight = 1'b1;
        step();
        Tick = 1'b1;
        repeat (178) step();
        checks++;
        if (Pipe_X_L !== 10'd284 || q_Run !== 1'b1 || Stop !== 1'b0) begin
            errors++; $display("FAIL hit_approach: got x=%0d run=%b stop=%b expected 284/1/0", Pipe_X_L, q_Run, Stop);
        end
        step();
        checks++;
        if (Stop !== 1'b1 || q_Hit !== 1'b1 || Pipe_X_L !== 10'd284) begin
            errors++; $display("FAIL hit_detect: got stop=%b hit=%b x=%0d expected 1/1/284", Stop, q_Hit, Pipe_X_L);
        end
        repeat (5) step();
        Tick = 1'b0;
        checks++;
        if (Pipe_X_L !== 10'd284 || Stop !== 1'b1) begin
            errors++; $display("FAIL hit_frozen: got x=%0d stop=%b expected 284/1", Pipe_X_L, Stop);
        end
    endtask

    task automatic test_floor();
        do_reset();
        set_bird(0, 20, 460, 479);
        q_Flight = 1'b1;
        step();
        checks++;
        if (q_Run !== 1'b1 || Stop !== 1'b0) begin
            errors++; $display("FAIL floor_entry: got run=%b stop=%b expected 1/0", q_Run, Stop);
        end
        step();
        checks++;
        if (Stop !== 1'b1 || q_Hit !== 1'b1) begin
            errors++; $display("FAIL floor_hit: got stop=%b hit=%b expected 1/1", Stop, q_Hit);
        end
    endtask

    task automatic test_handshake();
        do_reset();
        set_bird(230, 285, 220, 240);
        q_Flight = 1'b1;
        step();
        Tick = 1'b1;
        repeat (237) step();
        Tick = 1'b0;
        set_bird(230, 285, 460, 479);
        step();
        q_Flight = 1'b0; q_Initial = 1'b0;
        repeat (3) step();
        checks++;
        if (Stop !== 1'b1 || q_Hit !== 1'b1 || Score !== 8'd1) begin
            errors++; $display("FAIL hs_hold: got stop=%b hit=%b score=%0d expected 1/1/1", Stop, q_Hit, Score);
        end
        q_Initial = 1'b1;
        step();
        q_Initial = 1'b0;
        checks++;
        if (q_Idle !== 1'b1 || Stop !== 1'b0 || Score !== 8'd1 || Pipe_X_L !== 10'd640) begin
            errors++; $display("FAIL hs_release: got idle=%b stop=%b score=%0d x=%0d expected 1/0/1/640",
                               q_Idle, Stop, Score, Pipe_X_L);
        end
    endtask

    task automatic test_respawn();
        do_reset();
        set_bird(230, 285, 220, 240);
        q_Flight = 1'b1;
        step();
        Tick = 1'b1;
        repeat (320) step();
        checks++;
        if (Pipe_X_L !== 10'd0 || Stop !== 1'b0 || Score !== 8'd1) begin
            errors++; $display("FAIL respawn_edge: got x=%0d stop=%b score=%0d expected 0/0/1", Pipe_X_L, Stop, Score);
        end
        step();
        Tick = 1'b0;
        checks++;
        if (Pipe_X_L !== 10'd640 || Gap_Y_T < 10'd64 || Gap_Y_T > 10'd319 ||
            int'(Gap_Y_B) != int'(Gap_Y_T) + 160) begin
            errors++; $display("FAIL respawn_gap: got x=%0d gt=%0d gb=%0d expected 640, 64..319, gt+160",
                               Pipe_X_L, Gap_Y_T, Gap_Y_B);
        end
        checks++;
        if (int'(Gap_Y_T) != m_gt) begin
            errors++; $display("FAIL respawn_lfsr: got gt=%0d expected %0d", Gap_Y_T, m_gt);
        end
    endtask

    task automatic test_reset_mid_run();
        int  n;
        bit  found;
        do_reset();
        set_bird(230, 285, 170, 190);
        q_Flight = 1'b1;
        step();
        Tick = 1'b1;
        found = 1'b0;
        n = 0;
        while (!found && n < 2000) begin
            set_bird(230, 285, int'(Gap_Y_T) + 10, int'(Gap_Y_T) + 30);
            step();
            n++;
            if (Score == 8'd3 && Pipe_X_L == 10'd400) found = 1'b1;
        end
        Tick = 1'b0;
        checks++;
        if (found !== 1'b1 || Stop !== 1'b0) begin
            errors++; $display("FAIL midrun_reach: got score=%0d x=%0d stop=%b expected 3/400/0 within budget",
                               Score, Pipe_X_L, Stop);
        end
        reset = 1'b1;
        step();
        reset = 1'b0; q_Flight = 1'b0;
        checks++;
        if (q_Idle !== 1'b1 || Pipe_X_L !== 10'd640 || Score !== 8'd0 || Stop !== 1'b0) begin
            errors++; $display("FAIL midrun_reset: got idle=%b x=%0d score=%0d stop=%b expected 1/640/0/0",
                               q_Idle, Pipe_X_L, Score, Stop);
        end
    endtask

    task automatic test_random();
        int  xl;
        int  yt;
        logic [2:0] exp_flags;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                xl = $urandom_range(0, 600);
                yt = ($urandom_range(0, 9) < 7) ? $urandom_range(170, 250) : $urandom_range(0, 460);
                set_bird(xl, xl + $urandom_range(10, 60), yt, yt + $urandom_range(10, 40));
            end
            Tick      = ($urandom_range(0, 9) < 8);
            q_Flight  = ($urandom_range(0, 19) != 0);
            q_Initial = ($urandom_range(0, 4) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            step();
            exp_flags = (m_mode == 0) ? 3'b100 : ((m_mode == 1) ? 3'b010 : 3'b001);
            checks++;
            if ({q_Idle, q_Run, q_Hit} !== exp_flags || Stop !== 1'(m_stop)) begin
                errors++; $display("FAIL rnd_state cyc %0d: got flags=%b stop=%b expected %b/%0d",
                                   i, {q_Idle, q_Run, q_Hit}, Stop, exp_flags, m_stop);
            end
            checks++;
            if (int'(Pipe_X_L) != m_x || int'(Gap_Y_T) != m_gt || int'(Gap_Y_B) != m_gb) begin
                errors++; $display("FAIL rnd_pipe cyc %0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                                   i, Pipe_X_L, Gap_Y_T, Gap_Y_B, m_x, m_gt, m_gb);
            end
            checks++;
            if (int'(Score) != m_score) begin
                errors++; $display("FAIL rnd_score cyc %0d: got %0d expected %0d", i, Score, m_score);
            end
        end
        reset = 1'b0; Tick = 1'b0; q_Initial = 1'b0; q_Flight = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_pass();
        test_pipe_hit();
        test_floor();
        test_handshake();
        test_respawn();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_referee.md
PIPE_REFEREE -- requirements
Module: pipe_referee

Interface
REQ-001 Parameter PIPE_W, default 60, pipe width in pixels.
REQ-002 Parameter GAP_H, default 160, vertical gap height in pixels.
REQ-003 Parameter PIPE_STEP, default 2, pixels moved per Tick.
REQ-004 Parameter SPAWN_X, default 640, pipe left edge on (re)spawn.
REQ-005 Parameter FLOOR_Y, default 479, bird bottom at/after which a hit occurs.
REQ-006 Clk  in  1  single system clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 Tick  in  1  one-cycle movement-enable pulse (frame rate).
REQ-009 q_Initial, q_Flight  in  1 each  flight controller state flags.
REQ-010 Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B  in  10 each  bird bounding box, unsigned pixels.
REQ-011 Stop  out  1  registered; requests flight controller to leave flight.
REQ-012 Pipe_X_L  out  10  pipe left edge; pipe spans Pipe_X_L..Pipe_X_L+PIPE_W-1.
REQ-013 Gap_Y_T, Gap_Y_B  out  10 each  open gap rows, inclusive.
REQ-014 Score  out  8  unsigned pipes passed.
REQ-015 q_Idle, q_Run, q_Hit  out  1 each  one-hot state flags.

Function
REQ-016 One-hot FSM states Idle, Run, Hit; flags equal state bits.
REQ-017 Idle: Pipe_X_L=SPAWN_X, Gap_Y_T=160, Gap_Y_B=320, passed flag=0; Score holds; Idle->Run on q_Flight=1, Score cleared to 0 on that transition.
REQ-018 Run, Tick=1, no hit: Pipe_X_L >= PIPE_STEP -> Pipe_X_L -= PIPE_STEP; Pipe_X_L < PIPE_STEP -> respawn.
REQ-019 Respawn: Pipe_X_L=SPAWN_X, Gap_Y_T=64+lfsr[7:0] (64..319), Gap_Y_B=Gap_Y_T+GAP_H, passed flag cleared.
REQ-020 LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1, advances every clock in every state, value 8'hA5 after reset, never zero.
REQ-021 Hit condition (combinational, evaluated every Run cycle): (Bird_X_R >= Pipe_X_L and Bird_X_L <= Pipe_X_L+PIPE_W-1 and (Bird_Y_T < Gap_Y_T or Bird_Y_B > Gap_Y_B)) or Bird_Y_B >= FLOOR_Y; comparisons 11-bit unsigned, no wrap.
REQ-022 Hit detected at edge n -> state Hit and Stop=1 at edge n; visible cycle n+1; pipe, gap, Score frozen.
REQ-023 Score: in Run, passed flag=0 and Pipe_X_L+PIPE_W < Bird_X_L -> Score+1 (saturate at 255), passed flag set; at most one increment per pipe.
REQ-024 Simultaneous hit and Tick/respawn/score: hit wins; no movement, no respawn, no score increment that cycle.
REQ-025 Run with q_Flight=0 and no hit -> Idle, Stop stays 0.
REQ-026 Hit: Stop=1 until q_Initial=1 seen; then Idle with Stop=0 next edge; Score retained.
REQ-027 Tick ignored in Idle and Hit.

Reset
REQ-028 reset=1 at any edge, any state (incl. mid-Run/Hit): state Idle, Stop=0, Score=0, Pipe_X_L=SPAWN_X, Gap_Y_T=160, Gap_Y_B=320, passed=0, LFSR=8'hA5; reset overrides all other inputs.

Verification
REQ-029 Clean pass: reset, q_Flight=1, bird 230/285/220/240, 236 Ticks -> Pipe_X_L=168, Score=1 one cycle later, Stop=0 throughout.
REQ-030 Pipe collision: bird Y_T=100, Y_B=120, X as above, 178 Ticks -> Pipe_X_L=284, Stop=1 and q_Hit=1 next cycle, Pipe_X_L stays 284 on further Ticks.
REQ-031 Floor: enter Run with Bird_Y_B=479 -> Stop=1 one cycle after Run entry.
REQ-032 Respawn: bird in gap, 320 Ticks -> Pipe_X_L=0; next Tick -> Pipe_X_L=640, 64<=Gap_Y_T<=319, Gap_Y_B=Gap_Y_T+160.
REQ-033 Handshake: in Hit, q_Flight=0, q_Initial=0 -> Stop held 1; assert q_Initial=1 -> Idle, Stop=0 next cycle, Score unchanged.
REQ-034 Reset mid-Run at Pipe_X_L=400, Score=3 -> next cycle Idle, Pipe_X_L=640, Score=0, Stop=0.
